bram_frame_reader: RTL and testbench

Streams a contiguous region of a frame buffer BRAM out as a valid/ready beat stream. It sits directly downstream of the synchronous-read frame BRAM, which has one cycle of read latency. On a start pulse it walks `length` words from `base_addr` and absorbs the BRAM read latency and consumer backpressure with an internal buffer. It feeds the driver-monitoring compute stages with one word per cycle when unstalled.

---
 rtl/bram_frame_reader_if.sv | 13 +
 rtl/bram_frame_reader.sv | 156 +++++++++++++++
 tb/tb_bram_frame_reader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_frame_reader_if.sv
// Output stream bundle of bram_frame_reader: data/valid/last toward the consumer,
// ready back from it. The master modport is the reader side.
interface bram_frame_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bram_frame_reader.sv
// Walks `length` words of a 1-cycle-latency BRAM from `base_addr` into a 4-entry
// FIFO and streams them out. Optional stall counter: BRAM_READER_STALL_CNT_EN.
module bram_frame_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we,
    input  logic [DATA_WIDTH-1:0] bram_dout,
`ifdef BRAM_READER_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    bram_frame_reader_if.master   m_if
);
    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 4;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         rd_left_q, rd_left_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         beat_q, beat_d;
    logic                  pend_q, pend_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [DEPTH];
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pop_c;
    logic                  accept_c;

    assign pop_c    = valid_q && m_if.m_ready;
    assign accept_c = (state_q == S_IDLE) && start;

    // Entry 0 of the shift FIFO is the output register, so m_data is never muxed.
    assign m_if.m_data  = fifo_q[0];
    assign m_if.m_valid = valid_q;
    assign m_if.m_last  = last_q;
    assign bram_addr    = addr_q;
    assign bram_we      = 1'b0;
    assign busy         = busy_q;
    assign done         = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rd_left_q <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_left_q <= rd_left_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_left_d = rd_left_q;
        len_d     = len_q;
        beat_d    = beat_q;
        pend_d    = 1'b0;
        fifo_d    = fifo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = length;
                    rd_left_d = length;
                    beat_d    = LW'(1);
                    if (length == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_READ;
                        addr_d  = base_addr;
                    end
                end
            end
            S_READ: begin
                // Buffered plus in-flight words must leave a slot for this read.
                if ((cnt_q + 3'(pend_q)) < 3'(DEPTH)) begin
                    pend_d    = 1'b1;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    rd_left_d = rd_left_q - LW'(1);
                    if (rd_left_q == LW'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop_c && last_q) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (pop_c) begin
            for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
            beat_d = beat_q + LW'(1);
        end
        if (pend_q) fifo_d[2'(cnt_q - 3'(pop_c))] = bram_dout;

        cnt_d   = cnt_q + 3'(pend_q) - 3'(pop_c);
        valid_d = (cnt_d != '0);
        last_d  = (cnt_d != '0) && (beat_d == len_d);
        busy_d  = (state_d == S_READ) || (state_d == S_DRAIN);
        done_d  = (state_d == S_FINISH);
    end

`ifdef BRAM_READER_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of stalled valid cycles, restarted by each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept_c) begin
            stall_q <= '0;
        end else if (valid_q && !m_if.m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept_c;
`endif
endmodule

// File: tb/tb_bram_frame_reader.sv
// Self-checking bench for bram_frame_reader: BRAM model plus a reference that
// expects mem[(base+i) mod 2^16] for i < length, checked per scenario.
module tb_bram_frame_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] length;
    logic        busy;
    logic        done;
    logic [15:0] bram_addr;
    logic        bram_we;
    logic [31:0] bram_dout;
`ifdef BRAM_READER_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    bram_frame_reader_if #(.DATA_WIDTH(32)) m_if ();

    bram_frame_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .bram_addr    (bram_addr),
        .bram_we      (bram_we),
        .bram_dout    (bram_dout),
`ifdef BRAM_READER_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .m_if         (m_if)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    always @(posedge clk) bram_dout <= mem[bram_addr];

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    bit          lastf_q[$];
    int          done_cycle, done_cnt, first_valid, hold_err, ahead_err, stall_model;
    logic        busy_c1;
    logic [15:0] addr_c1;
    bit          addr_changed, timeout;

    // Reference: beat i carries mem[(b+i) mod 2^16], m_last only on beat len-1.
    function automatic int xfer_mismatches(input logic [15:0] b, input int len);
        int m;
        int n;
        m = (got_q.size() != len) ? 1 : 0;
        n = (got_q.size() < len) ? got_q.size() : len;
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== mem[16'(int'(b) + i)]) m++;
            if (lastf_q[i] !== (i == len - 1)) m++;
        end
        return m;
    endfunction

    // Runs one transfer, recording beats and timing; stops 3 cycles after done.
    task automatic do_xfer(input logic [15:0] b, input logic [16:0] len, input int ready_pct,
                           input int restart_at, input int budget);
        logic [15:0] addr0;
        logic        pv_stall;
        logic [31:0] pdata;
        logic        plast;
        int          acc;
        int          k;
        int          post;
        got_q.delete();
        lastf_q.delete();
        done_cycle = -1; done_cnt = 0; first_valid = -1; hold_err = 0; ahead_err = 0;
        stall_model = 0; addr_changed = 0; timeout = 0;
        @(posedge clk); #1;
        addr0 = bram_addr;
        start = 1'b1; base_addr = b; length = len; m_if.m_ready = 1'b1;
        pv_stall = 1'b0; pdata = '0; plast = 1'b0; acc = 0; k = 0; post = -1;
        while (1) begin
            @(posedge clk); #1;
            k++;
            start = (k == restart_at);
            if (k == restart_at) begin base_addr = ~b; length = 17'd3; end
            if (k == 1) begin busy_c1 = busy; addr_c1 = bram_addr; end
            if (bram_addr !== addr0) addr_changed = 1;
            if (done) begin done_cnt++; if (done_cycle < 0) done_cycle = k; end
            if (pv_stall && (!m_if.m_valid || m_if.m_data !== pdata || m_if.m_last !== plast))
                hold_err++;
            if (busy && int'(16'(bram_addr - b)) > acc + 4) ahead_err++;
            if (post >= 0) m_if.m_ready = 1'b1;
            else m_if.m_ready = (int'($urandom_range(0, 99)) < ready_pct);
            if (m_if.m_valid && !m_if.m_ready) stall_model++;
            if (m_if.m_valid && m_if.m_ready) begin
                got_q.push_back(m_if.m_data);
                lastf_q.push_back(m_if.m_last);
                acc++;
                if (first_valid < 0) first_valid = k;
            end
            pv_stall = m_if.m_valid && !m_if.m_ready;
            pdata = m_if.m_data;
            plast = m_if.m_last;
            if (post >= 0) post++;
            else if (done_cycle >= 0) post = 0;
            if (post >= 3) break;
            if (k >= budget) begin timeout = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_if.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, m_if.m_valid, m_if.m_last, bram_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {busy, done, m_if.m_valid, m_if.m_last, bram_we});
        end
        checks++;
        if (m_if.m_data !== 32'd0 || bram_addr !== 16'd0) begin
            errors++;
            $display("FAIL reset_data_addr: got data %h addr %h required 0 0", m_if.m_data, bram_addr);
        end
`ifdef BRAM_READER_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int mm;
        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 32'h0000_00A0 + i;
        do_xfer(16'h0010, 17'd4, 100, 0, 50);
        mm = xfer_mismatches(16'h0010, 4);
        checks++;
        if (mm !== 0 || timeout) begin
            errors++;
            $display("FAIL basic_data: got %0d mismatches (%0d beats) required 0 (4 beats)", mm, got_q.size());
        end
        checks++;
        if (first_valid !== 3 || done_cycle !== 7 || done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_timing: got valid@%0d done@%0d x%0d required valid@3 done@7 x1",
                     first_valid, done_cycle, done_cnt);
        end
        checks++;
        if (busy_c1 !== 1'b1 || addr_c1 !== 16'h0010) begin
            errors++;
            $display("FAIL basic_cycle1: got busy %b addr %h required 1 0010", busy_c1, addr_c1);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] b;
        int mm;
        for (int r = 0; r < 3; r++) begin
            b = 16'($urandom_range(0, 65535));
            do_xfer(b, 17'd16, 50, 0, 400);
            mm = xfer_mismatches(b, 16);
            checks++;
            if (mm !== 0 || timeout) begin
                errors++;
                $display("FAIL bp_data: got %0d mismatches (%0d beats) required 0 (16 beats)", mm, got_q.size());
            end
            checks++;
            if (hold_err !== 0 || ahead_err !== 0 || done_cnt !== 1) begin
                errors++;
                $display("FAIL bp_hold_ahead: got hold %0d ahead %0d done x%0d required 0 0 x1",
                         hold_err, ahead_err, done_cnt);
            end
`ifdef BRAM_READER_STALL_CNT_EN
            checks++;
            if (stall_cycles !== 32'(stall_model)) begin
                errors++;
                $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cycles, stall_model);
            end
`endif
        end
    endtask

    task automatic test_wrap();
        int mm;
        do_xfer(16'hFFFE, 17'd4, 60, 0, 200);
        mm = xfer_mismatches(16'hFFFE, 4);
        checks++;
        if (mm !== 0 || timeout || addr_c1 !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap: got %0d mismatches first addr %h required 0 FFFE", mm, addr_c1);
        end
    endtask

    task automatic test_zero_length();
        do_xfer(16'h1234, 17'd0, 100, 0, 20);
        checks++;
        if (done_cycle !== 1 || done_cnt !== 1 || busy_c1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done@%0d x%0d busy %b required done@1 x1 busy 0",
                     done_cycle, done_cnt, busy_c1);
        end
        checks++;
        if (got_q.size() !== 0 || first_valid !== -1 || addr_changed) begin
            errors++;
            $display("FAIL zero_quiet: got %0d beats addr_changed %0d required 0 0", got_q.size(), addr_changed);
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] b;
        int mm;
        b = 16'($urandom_range(0, 65535));
        do_xfer(b, 17'd8, 70, 4, 300);
        mm = xfer_mismatches(b, 8);
        checks++;
        if (mm !== 0 || done_cnt !== 1 || timeout) begin
            errors++;
            $display("FAIL start_busy: got %0d mismatches %0d beats done x%0d required 0 8 x1",
                     mm, got_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] b;
        int acc;
        int bad;
        int mm;
        b = 16'($urandom_range(0, 65535));
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = 17'd8; m_if.m_ready = 1'b1; acc = 0;
        for (int k = 0; k < 40 && acc < 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (m_if.m_valid) acc++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, m_if.m_valid, m_if.m_last} !== 4'b0 || m_if.m_data !== 32'd0 ||
            bram_addr !== 16'd0 || acc != 2) begin
            errors++;
            $display("FAIL rst_mid_clear: got flags %b data %h addr %h beats %0d required 0000 0 0 2",
                     {busy, done, m_if.m_valid, m_if.m_last}, m_if.m_data, bram_addr, acc);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || m_if.m_valid || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d active cycles required 0", bad);
        end
        b = ~b;
        do_xfer(b, 17'd5, 100, 0, 100);
        mm = xfer_mismatches(b, 5);
        checks++;
        if (mm !== 0 || done_cnt !== 1 || timeout) begin
            errors++;
            $display("FAIL rst_mid_restart: got %0d mismatches done x%0d required 0 x1", mm, done_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] b;
        int len;
        int mm;
        for (int r = 0; r < 4; r++) begin
            b = 16'($urandom_range(0, 65535));
            len = int'($urandom_range(1, 24));
            do_xfer(b, 17'(len), int'($urandom_range(30, 100)), 0, 600);
            mm = xfer_mismatches(b, len);
            checks++;
            if (mm !== 0 || hold_err !== 0 || ahead_err !== 0 || done_cnt !== 1 || timeout) begin
                errors++;
                $display("FAIL random_len%0d: got %0d mismatches hold %0d ahead %0d done x%0d required 0 0 0 x1",
                         len, mm, hold_err, ahead_err, done_cnt);
            end
        end
    endtask

    task automatic test_full_region();
        logic [15:0] b;
        int mm;
        b = 16'($urandom_range(0, 65535));
        do_xfer(b, 17'h10000, 100, 0, 66000);
        mm = xfer_mismatches(b, 65536);
        checks++;
        if (mm !== 0 || done_cnt !== 1 || timeout) begin
            errors++;
            $display("FAIL full_region: got %0d mismatches %0d beats required 0 65536", mm, got_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_frame();
        test_random();
        test_full_region();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
